// File: rtl/sdram_port_arbiter_if.sv
// Bundle of every handshake/bus signal between the arbiter, its two clients and the SDRAM controller.
// Latency: none; this is plain wiring.
// Backpressure: none here. Clients hold a level request until they see their ack.
// Ports: client 0 is fetch (read only), client 1 is data (read/write), the imem_* and omem_* signals
// face the controller, and obusy/otimeout are status.
// Modport slave is the arbiter's view; modport master is the view of the clients and controller.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 128
);
  logic              i0_read_req;
  logic [ADDR_W-1:0] i0_read_address;
  logic [DATA_W-1:0] o0_read_data;
  logic              o0_read_ack;

  logic              i1_write_req;
  logic [ADDR_W-1:0] i1_write_address;
  logic [DATA_W-1:0] i1_write_data;
  logic              o1_write_ack;
  logic              i1_read_req;
  logic [ADDR_W-1:0] i1_read_address;
  logic [DATA_W-1:0] o1_read_data;
  logic              o1_read_ack;

  logic              omem_write_req;
  logic              omem_read_req;
  logic [ADDR_W-1:0] omem_write_address;
  logic [ADDR_W-1:0] omem_read_address;
  logic [DATA_W-1:0] omem_write_data;
  logic              imem_write_ack;
  logic              imem_read_ack;
  logic [DATA_W-1:0] imem_read_data;
  logic              imem_in_use;

  logic              obusy;
  logic              otimeout;

  modport slave (
    input  i0_read_req, i0_read_address,
    output o0_read_data, o0_read_ack,
    input  i1_write_req, i1_write_address, i1_write_data, i1_read_req, i1_read_address,
    output o1_write_ack, o1_read_data, o1_read_ack,
    output omem_write_req, omem_read_req, omem_write_address, omem_read_address, omem_write_data,
    input  imem_write_ack, imem_read_ack, imem_read_data, imem_in_use,
    output obusy, otimeout
  );

  modport master (
    output i0_read_req, i0_read_address,
    input  o0_read_data, o0_read_ack,
    output i1_write_req, i1_write_address, i1_write_data, i1_read_req, i1_read_address,
    input  o1_write_ack, o1_read_data, o1_read_ack,
    input  omem_write_req, omem_read_req, omem_write_address, omem_read_address, omem_write_data,
    output imem_write_ack, imem_read_ack, imem_read_data, imem_in_use,
    input  obusy, otimeout
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port between fetch (client 0, read) and data (client 1, read/write).
// Latency: request seen in IDLE at cycle 0 -> controller request from cycle 1 -> client ack 1 cycle after controller ack.
// Backpressure: one transaction in flight; other requests stay pending (level) until the FSM returns to IDLE.
// Ports: iclk, ireset (synchronous, active-high), bus (slave modport of sdram_port_arbiter_if).
// All outputs are registered. Ties alternate between clients; client 1 issues its write before its read.
module sdram_port_arbiter #(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 4095
) (
  input  logic                 iclk,
  input  logic                 ireset,
  sdram_port_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state;
  logic              last_client;  // client of the most recent grant; also the client in flight
  logic              cur_write;    // latched op of the transaction in flight
  logic [CNT_W-1:0]  cnt;

  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [DATA_W-1:0] rd0_data_q;
  logic [DATA_W-1:0] rd1_data_q;
  logic              wr_req_q;
  logic              rd_req_q;
  logic              ack0_q;
  logic              ack1w_q;
  logic              ack1r_q;
  logic              busy_q;
  logic              timeout_q;

  logic pend0;
  logic pend1;
  logic sel1;
  logic sel_write;

  assign pend0     = bus.i0_read_req;
  assign pend1     = bus.i1_write_req | bus.i1_read_req;
  // On a tie the client that did not win last time gets the port.
  assign sel1      = pend1 & (~pend0 | ~last_client);
  assign sel_write = sel1 & bus.i1_write_req;

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state       <= IDLE;
      last_client <= 1'b1;
      cur_write   <= 1'b0;
      cnt         <= '0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      wr_data_q   <= '0;
      rd0_data_q  <= '0;
      rd1_data_q  <= '0;
      wr_req_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      ack0_q      <= 1'b0;
      ack1w_q     <= 1'b0;
      ack1r_q     <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      // Client acks are single-cycle pulses; only the WAIT->RESP edge raises one.
      ack0_q  <= 1'b0;
      ack1w_q <= 1'b0;
      ack1r_q <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (pend0 | pend1) begin
            last_client <= sel1;
            cur_write   <= sel_write;
            busy_q      <= 1'b1;
            state       <= ISSUE;
            if (sel_write) begin
              wr_addr_q <= bus.i1_write_address;
              wr_data_q <= bus.i1_write_data;
              wr_req_q  <= 1'b1;
            end else begin
              rd_addr_q <= sel1 ? bus.i1_read_address : bus.i0_read_address;
              rd_req_q  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          // Drop the request on the same edge in_use is seen so the controller
          // cannot accept it a second time.
          if (bus.imem_in_use) begin
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cur_write && bus.imem_write_ack) begin
            ack1w_q <= 1'b1;
            state   <= RESP;
          end else if (!cur_write && bus.imem_read_ack) begin
            if (last_client) begin
              rd1_data_q <= bus.imem_read_data;
              ack1r_q    <= 1'b1;
            end else begin
              rd0_data_q <= bus.imem_read_data;
              ack0_q     <= 1'b1;
            end
            state <= RESP;
          end
        end
        RESP: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Watchdog only flags a stuck controller; the transaction keeps waiting.
      if (state == ISSUE || state == WAIT) begin
        if (cnt != CNT_W'(TIMEOUT))
          cnt <= cnt + 1'b1;
        if (cnt >= CNT_W'(TIMEOUT - 1))
          timeout_q <= 1'b1;
      end
    end
  end

  assign bus.omem_write_req     = wr_req_q;
  assign bus.omem_read_req      = rd_req_q;
  assign bus.omem_write_address = wr_addr_q;
  assign bus.omem_read_address  = rd_addr_q;
  assign bus.omem_write_data    = wr_data_q;
  assign bus.o0_read_data       = rd0_data_q;
  assign bus.o0_read_ack        = ack0_q;
  assign bus.o1_read_data       = rd1_data_q;
  assign bus.o1_read_ack        = ack1r_q;
  assign bus.o1_write_ack       = ack1w_q;
  assign bus.obusy              = busy_q;
  assign bus.otimeout           = timeout_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter; the controller side is driven cycle by cycle.
// Latency: stimulus is driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: the controller's in_use/ack timing is scripted per scenario.
module tb_sdram_port_arbiter;
  logic iclk;
  logic ireset;
  int   checks = 0;
  int   errors = 0;

  sdram_port_arbiter_if #(.ADDR_W(22), .DATA_W(128)) bus ();

  sdram_port_arbiter #(.ADDR_W(22), .DATA_W(128), .TIMEOUT(20)) dut (
    .iclk   (iclk),
    .ireset (ireset),
    .bus    (bus.slave)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic do_reset();
    ireset = 1'b1;
    tick();
    tick();
    ireset = 1'b0;
  endtask

  // Controller takes the pending request.
  task automatic accept();
    bus.imem_in_use = 1'b1;
    tick();
    bus.imem_in_use = 1'b0;
  endtask

  task automatic ack_read(input logic [127:0] d);
    bus.imem_read_data = d;
    bus.imem_read_ack  = 1'b1;
    tick();
    bus.imem_read_ack  = 1'b0;
    bus.imem_read_data = '0;
  endtask

  task automatic ack_write();
    bus.imem_write_ack = 1'b1;
    tick();
    bus.imem_write_ack = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.omem_read_req !== 1'b0) begin errors++; $display("FAIL rst_rd_req got %b exp 0", bus.omem_read_req); end
    checks++; if (bus.omem_write_req !== 1'b0) begin errors++; $display("FAIL rst_wr_req got %b exp 0", bus.omem_write_req); end
    checks++; if (bus.omem_write_address !== 22'h0) begin errors++; $display("FAIL rst_wr_addr got %h exp 0", bus.omem_write_address); end
    checks++; if (bus.omem_write_data !== 128'h0) begin errors++; $display("FAIL rst_wr_data got %h exp 0", bus.omem_write_data); end
    checks++; if ({bus.o0_read_ack, bus.o1_read_ack, bus.o1_write_ack} !== 3'b000) begin errors++; $display("FAIL rst_acks got %b exp 000", {bus.o0_read_ack, bus.o1_read_ack, bus.o1_write_ack}); end
    checks++; if ({bus.obusy, bus.otimeout} !== 2'b00) begin errors++; $display("FAIL rst_status got %b exp 00", {bus.obusy, bus.otimeout}); end
    checks++; if (bus.o0_read_data !== 128'h0) begin errors++; $display("FAIL rst_rd0_data got %h exp 0", bus.o0_read_data); end
  endtask

  task automatic test_fetch();
    logic [127:0] d;
    d = {16{8'hA5}};
    bus.i0_read_address = 22'h00010;
    bus.i0_read_req = 1'b1;
    tick(); // grant
    checks++; if (bus.omem_read_req !== 1'b1) begin errors++; $display("FAIL fetch_req got %b exp 1", bus.omem_read_req); end
    checks++; if (bus.omem_write_req !== 1'b0) begin errors++; $display("FAIL fetch_no_wr got %b exp 0", bus.omem_write_req); end
    checks++; if (bus.omem_read_address !== 22'h00010) begin errors++; $display("FAIL fetch_addr got %h exp 00010", bus.omem_read_address); end
    checks++; if (bus.obusy !== 1'b1) begin errors++; $display("FAIL fetch_busy got %b exp 1", bus.obusy); end
    tick(); // still waiting for the controller
    checks++; if (bus.omem_read_req !== 1'b1) begin errors++; $display("FAIL fetch_req_hold got %b exp 1", bus.omem_read_req); end
    accept();
    checks++; if (bus.omem_read_req !== 1'b0) begin errors++; $display("FAIL fetch_req_drop got %b exp 0", bus.omem_read_req); end
    checks++; if (bus.o0_read_ack !== 1'b0) begin errors++; $display("FAIL fetch_early_ack got %b exp 0", bus.o0_read_ack); end
    ack_read(d);
    checks++; if (bus.o0_read_ack !== 1'b1) begin errors++; $display("FAIL fetch_ack got %b exp 1", bus.o0_read_ack); end
    checks++; if (bus.o0_read_data !== d) begin errors++; $display("FAIL fetch_data got %h exp %h", bus.o0_read_data, d); end
    checks++; if ({bus.o1_read_ack, bus.o1_write_ack} !== 2'b00) begin errors++; $display("FAIL fetch_other_ack got %b exp 00", {bus.o1_read_ack, bus.o1_write_ack}); end
    bus.i0_read_req = 1'b0;
    tick();
    checks++; if (bus.o0_read_ack !== 1'b0) begin errors++; $display("FAIL fetch_ack_pulse got %b exp 0", bus.o0_read_ack); end
    checks++; if (bus.obusy !== 1'b0) begin errors++; $display("FAIL fetch_idle got %b exp 0", bus.obusy); end
    checks++; if (bus.o0_read_data !== d) begin errors++; $display("FAIL fetch_data_hold got %h exp %h", bus.o0_read_data, d); end
  endtask

  task automatic test_write();
    logic [127:0] d;
    d = '1;
    bus.i1_write_address = 22'h3FFFFF;
    bus.i1_write_data = d;
    bus.i1_write_req = 1'b1;
    tick();
    checks++; if (bus.omem_write_req !== 1'b1) begin errors++; $display("FAIL wr_req got %b exp 1", bus.omem_write_req); end
    checks++; if (bus.omem_read_req !== 1'b0) begin errors++; $display("FAIL wr_no_rd got %b exp 0", bus.omem_read_req); end
    // Inputs change after grant; latched values must not follow.
    bus.i1_write_address = 22'h000001;
    bus.i1_write_data = '0;
    tick();
    checks++; if (bus.omem_write_address !== 22'h3FFFFF) begin errors++; $display("FAIL wr_addr got %h exp 3fffff", bus.omem_write_address); end
    checks++; if (bus.omem_write_data !== d) begin errors++; $display("FAIL wr_data got %h exp %h", bus.omem_write_data, d); end
    checks++; if (bus.omem_write_req !== 1'b1) begin errors++; $display("FAIL wr_req_hold got %b exp 1", bus.omem_write_req); end
    accept();
    checks++; if (bus.omem_write_req !== 1'b0) begin errors++; $display("FAIL wr_req_drop got %b exp 0", bus.omem_write_req); end
    ack_write();
    checks++; if (bus.o1_write_ack !== 1'b1) begin errors++; $display("FAIL wr_ack got %b exp 1", bus.o1_write_ack); end
    checks++; if ({bus.o0_read_ack, bus.o1_read_ack} !== 2'b00) begin errors++; $display("FAIL wr_other_ack got %b exp 00", {bus.o0_read_ack, bus.o1_read_ack}); end
    bus.i1_write_req = 1'b0;
    tick();
    checks++; if (bus.o1_write_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_pulse got %b exp 0", bus.o1_write_ack); end
    checks++; if (bus.o0_read_data !== {16{8'hA5}}) begin errors++; $display("FAIL wr_fetch_untouched got %h", bus.o0_read_data); end
    checks++; if (bus.omem_write_address !== 22'h3FFFFF) begin errors++; $display("FAIL wr_addr_hold got %h exp 3fffff", bus.omem_write_address); end
  endtask

  task automatic test_wr_rd_order();
    logic [127:0] d;
    d = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    bus.i1_write_address = 22'h000100;
    bus.i1_write_data = 128'h5A5A;
    bus.i1_read_address = 22'h000200;
    bus.i1_write_req = 1'b1;
    bus.i1_read_req = 1'b1;
    tick();
    checks++; if ({bus.omem_write_req, bus.omem_read_req} !== 2'b10) begin errors++; $display("FAIL order_first got %b exp 10", {bus.omem_write_req, bus.omem_read_req}); end
    checks++; if (bus.omem_write_address !== 22'h000100) begin errors++; $display("FAIL order_wr_addr got %h exp 000100", bus.omem_write_address); end
    accept();
    ack_write();
    checks++; if ({bus.o1_write_ack, bus.o1_read_ack} !== 2'b10) begin errors++; $display("FAIL order_ack1 got %b exp 10", {bus.o1_write_ack, bus.o1_read_ack}); end
    bus.i1_write_req = 1'b0;
    tick(); // back to IDLE
    checks++; if ({bus.omem_write_req, bus.omem_read_req} !== 2'b00) begin errors++; $display("FAIL order_gap got %b exp 00", {bus.omem_write_req, bus.omem_read_req}); end
    tick(); // read granted
    checks++; if ({bus.omem_write_req, bus.omem_read_req} !== 2'b01) begin errors++; $display("FAIL order_second got %b exp 01", {bus.omem_write_req, bus.omem_read_req}); end
    checks++; if (bus.omem_read_address !== 22'h000200) begin errors++; $display("FAIL order_rd_addr got %h exp 000200", bus.omem_read_address); end
    accept();
    ack_read(d);
    checks++; if ({bus.o1_write_ack, bus.o1_read_ack, bus.o0_read_ack} !== 3'b010) begin errors++; $display("FAIL order_ack2 got %b exp 010", {bus.o1_write_ack, bus.o1_read_ack, bus.o0_read_ack}); end
    checks++; if (bus.o1_read_data !== d) begin errors++; $display("FAIL order_rd_data got %h exp %h", bus.o1_read_data, d); end
    bus.i1_read_req = 1'b0;
    tick();
  endtask

  task automatic test_tie();
    logic [127:0] d;
    logic [21:0]  a0;
    logic [21:0]  a1;
    a0 = 22'h000ABC;
    a1 = 22'h155555;
    bus.i0_read_address = a0;
    bus.i1_read_address = a1;
    bus.i0_read_req = 1'b1;
    bus.i1_read_req = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      d = {4{32'hC0DE0000 + 32'(i)}};
      tick(); // grant
      checks++; if (bus.omem_read_address !== ((i % 2 == 0) ? a0 : a1)) begin errors++; $display("FAIL tie_addr[%0d] got %h exp %h", i, bus.omem_read_address, (i % 2 == 0) ? a0 : a1); end
      accept();
      ack_read(d);
      if (i % 2 == 0) begin
        checks++; if ({bus.o0_read_ack, bus.o1_read_ack} !== 2'b10) begin errors++; $display("FAIL tie_ack[%0d] got %b exp 10", i, {bus.o0_read_ack, bus.o1_read_ack}); end
        checks++; if (bus.o0_read_data !== d) begin errors++; $display("FAIL tie_data[%0d] got %h exp %h", i, bus.o0_read_data, d); end
      end else begin
        checks++; if ({bus.o0_read_ack, bus.o1_read_ack} !== 2'b01) begin errors++; $display("FAIL tie_ack[%0d] got %b exp 01", i, {bus.o0_read_ack, bus.o1_read_ack}); end
        checks++; if (bus.o1_read_data !== d) begin errors++; $display("FAIL tie_data[%0d] got %h exp %h", i, bus.o1_read_data, d); end
      end
      tick(); // RESP -> IDLE
    end
    bus.i0_read_req = 1'b0;
    bus.i1_read_req = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    bus.i0_read_address = 22'h000777;
    bus.i0_read_req = 1'b1;
    tick(); // grant
    bus.i0_read_req = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    checks++; if (bus.otimeout !== 1'b0) begin errors++; $display("FAIL stall_early got %b exp 0", bus.otimeout); end
    checks++; if (bus.omem_read_req !== 1'b1) begin errors++; $display("FAIL stall_req got %b exp 1", bus.omem_read_req); end
    tick();
    checks++; if (bus.otimeout !== 1'b1) begin errors++; $display("FAIL stall_timeout got %b exp 1", bus.otimeout); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if ({bus.otimeout, bus.omem_read_req, bus.obusy} !== 3'b111) begin errors++; $display("FAIL stall_sticky got %b exp 111", {bus.otimeout, bus.omem_read_req, bus.obusy}); end
    ireset = 1'b1;
    tick();
    ireset = 1'b0;
    checks++; if ({bus.otimeout, bus.omem_read_req, bus.omem_write_req, bus.obusy} !== 4'b0000) begin errors++; $display("FAIL stall_reset got %b exp 0000", {bus.otimeout, bus.omem_read_req, bus.omem_write_req, bus.obusy}); end
    checks++; if ({bus.omem_read_address, bus.o0_read_data} !== 150'h0) begin errors++; $display("FAIL stall_reset_regs got %h exp 0", {bus.omem_read_address, bus.o0_read_data}); end
  endtask

  task automatic test_reset_in_wait();
    logic [127:0] d;
    d = 128'hFACE_0000_0000_0000_0000_0000_0000_BEEF;
    bus.i1_read_address = 22'h000042;
    bus.i1_read_req = 1'b1;
    tick();
    accept(); // now in WAIT
    ireset = 1'b1;
    bus.i1_read_req = 1'b0;
    tick();
    ireset = 1'b0;
    tick();
    checks++; if ({bus.o0_read_ack, bus.o1_read_ack, bus.o1_write_ack, bus.obusy} !== 4'b0000) begin errors++; $display("FAIL rstwait_quiet got %b exp 0000", {bus.o0_read_ack, bus.o1_read_ack, bus.o1_write_ack, bus.obusy}); end
    bus.i0_read_address = 22'h000123;
    bus.i0_read_req = 1'b1;
    tick();
    checks++; if ({bus.omem_read_req, bus.omem_read_address} !== {1'b1, 22'h000123}) begin errors++; $display("FAIL rstwait_new_req got %h exp 1 000123", {bus.omem_read_req, bus.omem_read_address}); end
    accept();
    ack_read(d);
    checks++; if ({bus.o0_read_ack, bus.o1_read_ack} !== 2'b10) begin errors++; $display("FAIL rstwait_ack got %b exp 10", {bus.o0_read_ack, bus.o1_read_ack}); end
    checks++; if (bus.o0_read_data !== d) begin errors++; $display("FAIL rstwait_data got %h exp %h", bus.o0_read_data, d); end
    bus.i0_read_req = 1'b0;
    tick();
    checks++; if ({bus.o0_read_ack, bus.obusy} !== 2'b00) begin errors++; $display("FAIL rstwait_done got %b exp 00", {bus.o0_read_ack, bus.obusy}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    ireset = 1'b1;
    bus.i0_read_req = 1'b0;
    bus.i0_read_address = '0;
    bus.i1_write_req = 1'b0;
    bus.i1_write_address = '0;
    bus.i1_write_data = '0;
    bus.i1_read_req = 1'b0;
    bus.i1_read_address = '0;
    bus.imem_write_ack = 1'b0;
    bus.imem_read_ack = 1'b0;
    bus.imem_read_data = '0;
    bus.imem_in_use = 1'b0;
    test_reset();
    test_fetch();
    test_write();
    test_wr_rd_order();
    test_tie();
    test_stall();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
